pixel_op_sequencer: RTL and testbench

Frame-level controller that streams a block of 8-bit pixels from a source memory through the registered pixel operator (brighten / darken / threshold / invert) and writes results to a destination memory. It latches the operation configuration once per frame and issues one read per cycle. It aligns addresses with the operator's one-cycle output register and reports busy, done and abort status to the host control logic. The block sits between the host register file, the pixel RAMs and one pixel operator instance.

---
 rtl/pixel_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_pixel_op_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pixel_op_sequencer.sv
// rtl/pixel_op_sequencer.sv - frame sequencer streaming source pixels through a registered pixel operator
`timescale 1ns/1ps
//
// Reads NUM_PIX pixels starting at src_base, one per cycle, and feeds them to an
// external registered pixel operator. It writes each operator result to dst_base + k
// and raises done for one cycle when the frame is finished. The operator config is
// latched when start is accepted.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort                    frame start (IDLE only), early stop (RUN only)
//   cfg_select/value/threshold      operator configuration, latched on start
//   src_base, dst_base              first source / destination address
//   rd_en, rd_addr, rd_data         source memory port (1-cycle read latency)
//   op_inbyte, op_select,
//   op_value, op_threshold,
//   op_outbyte                      pixel operator connection (1-cycle latency)
//   wr_en, wr_addr, wr_data         destination memory write port
//   busy, done, aborted, pix_count  frame status

module pixel_op_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int NUM_PIX = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_select,
    input  logic [7:0]        cfg_value,
    input  logic [7:0]        cfg_threshold,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        op_inbyte,
    output logic [1:0]        op_select,
    output logic [7:0]        op_value,
    output logic [7:0]        op_threshold,
    input  logic [7:0]        op_outbyte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   pix_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] issue_idx;
    logic              v1;
    logic              v2;
    logic [ADDR_W-1:0] k1;
    logic [ADDR_W-1:0] k2;
    logic              last_issue;

    assign last_issue = (issue_idx == LAST_IDX);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last_issue || abort) next_state = S_DRAIN;
            // v2 follows v1 one cycle later, so once v1 is clear the final
            // write is happening this cycle and DONE can follow immediately.
            S_DRAIN: if (!v1) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            op_select    <= '0;
            op_value     <= '0;
            op_threshold <= '0;
            issue_idx    <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            k1           <= '0;
            k2           <= '0;
            pix_count    <= '0;
            aborted      <= 1'b0;
        end else begin
            state <= next_state;
            v1    <= (state == S_RUN);
            k1    <= issue_idx;
            v2    <= v1;
            k2    <= k1;
            if (v2) pix_count <= pix_count + (ADDR_W+1)'(1);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q        <= src_base;
                        dst_q        <= dst_base;
                        op_select    <= cfg_select;
                        op_value     <= cfg_value;
                        op_threshold <= cfg_threshold;
                        issue_idx    <= '0;
                        pix_count    <= '0;
                        aborted      <= 1'b0;
                    end
                end
                S_RUN: begin
                    issue_idx <= issue_idx + ADDR_W'(1);
                    // An abort on the final issue ends the frame normally.
                    if (abort && !last_issue) aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_en   = (state == S_RUN);
    assign rd_addr = src_q + issue_idx;
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);

    // Data paths are qualified by their valid so idle and reset leave them at zero.
    assign op_inbyte = v1 ? rd_data : 8'h00;
    assign wr_en     = v2;
    assign wr_addr   = dst_q + k2;
    assign wr_data   = v2 ? op_outbyte : 8'h00;

endmodule

// File: tb/tb_pixel_op_sequencer.sv
// tb/tb_pixel_op_sequencer.sv - randomized self-checking bench for pixel_op_sequencer
`timescale 1ns/1ps

module tb_pixel_op_sequencer;

    localparam int AW = 16;
    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [1:0]    cfg_select;
    logic [7:0]    cfg_value, cfg_threshold;
    logic [AW-1:0] src_base, dst_base;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    op_inbyte;
    logic [1:0]    op_select;
    logic [7:0]    op_value, op_threshold;
    logic [7:0]    op_outbyte;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy, done, aborted;
    logic [AW:0]   pix_count;

    logic [7:0]    src_mem [65536];
    int            tests = 0;
    int            fails = 0;

    pixel_op_sequencer #(.ADDR_W(AW), .NUM_PIX(NP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_select(cfg_select), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
        .src_base(src_base), .dst_base(dst_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .op_inbyte(op_inbyte), .op_select(op_select), .op_value(op_value),
        .op_threshold(op_threshold), .op_outbyte(op_outbyte),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .aborted(aborted), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] op_ref(logic [1:0] sel, logic [7:0] val,
                                          logic [7:0] thr, logic [7:0] x);
        int s;
        case (sel)
            2'd0: begin s = int'(x) + int'(val); return (s > 255) ? 8'hFF : 8'(s); end
            2'd1: begin s = int'(x) - int'(val); return (s < 0) ? 8'h00 : 8'(s); end
            2'd2: return (x > thr) ? 8'hFF : 8'h00;
            default: return ~x;
        endcase
    endfunction

    // Source RAM and pixel operator, each with one cycle of latency.
    always @(posedge clk) rd_data <= rd_en ? src_mem[rd_addr] : 8'h00;
    always @(posedge clk) op_outbyte <= op_ref(op_select, op_value, op_threshold, op_inbyte);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".rd_en"}, 32'(rd_en), 0);
        chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
        chk({tag, ".op_inbyte"}, 32'(op_inbyte), 0);
        chk({tag, ".op_cfg"}, {14'(0), op_select, op_value, op_threshold}, 0);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".wr_data"}, 32'(wr_data), 0);
        chk({tag, ".status"}, {29'(0), busy, done, aborted}, 0);
        chk({tag, ".pix_count"}, 32'(pix_count), 0);
    endtask

    // One frame: start accepted at the posedge after the first negedge, then
    // every cycle's outputs compared against the frame-level timing rules.
    task automatic run_frame(string name, logic [1:0] sel, logic [7:0] val, logic [7:0] thr,
                             logic [AW-1:0] src, logic [AW-1:0] dst,
                             int abort_at, bit pulse_start, int reset_at);
        int n;
        logic [AW-1:0] a;
        string t;
        n = (abort_at > 0) ? abort_at : NP;
        @(negedge clk);
        cfg_select = sel; cfg_value = val; cfg_threshold = thr;
        src_base = src; dst_base = dst; start = 1'b1; abort = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            t = $sformatf("%s.c%0d", name, c);
            chk({t, ".rd_en"}, 32'(rd_en), 32'(c <= n));
            if (c <= n) begin
                a = src + AW'(c - 1);
                chk({t, ".rd_addr"}, 32'(rd_addr), 32'(a));
            end
            if (c >= 2 && c <= n + 1) begin
                a = src + AW'(c - 2);
                chk({t, ".op_inbyte"}, 32'(op_inbyte), 32'(src_mem[a]));
            end else
                chk({t, ".op_inbyte"}, 32'(op_inbyte), 0);
            chk({t, ".op_cfg"}, {14'(0), op_select, op_value, op_threshold}, {14'(0), sel, val, thr});
            chk({t, ".wr_en"}, 32'(wr_en), 32'(c >= 3 && c <= n + 2));
            if (c >= 3 && c <= n + 2) begin
                a = dst + AW'(c - 3);
                chk({t, ".wr_addr"}, 32'(wr_addr), 32'(a));
                a = src + AW'(c - 3);
                chk({t, ".wr_data"}, 32'(wr_data), 32'(op_ref(sel, val, thr, src_mem[a])));
            end
            chk({t, ".busy"}, 32'(busy), 32'(c <= n + 2));
            chk({t, ".done"}, 32'(done), 32'(c == n + 3));
            chk({t, ".aborted"}, 32'(aborted), 32'(abort_at > 0 && c > abort_at));
            chk({t, ".pix_count"}, 32'(pix_count), 32'((c < 3) ? 0 : ((c - 3 > n) ? n : c - 3)));
            // cfg inputs wander during the frame; the latched copies must not follow.
            cfg_select = 2'($urandom); cfg_value = 8'($urandom); cfg_threshold = 8'($urandom);
            src_base = 16'($urandom); dst_base = 16'($urandom);
            abort = (c == abort_at);
            start = pulse_start ? ((c % 2) == 1) : 1'b0;
            if (c == reset_at) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero({t, ".rst_async"});
                @(negedge clk);
                chk_all_zero({t, ".rst_hold"});
                start = 1'b0; abort = 1'b0;
                @(negedge clk);
                chk_all_zero({t, ".rst_hold2"});
                rst_n = 1'b1;
                return;
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_select = '0; cfg_value = '0; cfg_threshold = '0;
        src_base = '0; dst_base = '0;
        for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
        src_mem[16'h0100] = 8'h00; src_mem[16'h0101] = 8'h10;
        src_mem[16'h0102] = 8'hD0; src_mem[16'h0103] = 8'hFF;
        src_mem[16'h0200] = 8'h7F; src_mem[16'h0201] = 8'h80; src_mem[16'h0202] = 8'h81;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_frame("brighten", 2'd0, 8'h30, 8'h00, 16'h0100, 16'h2000, 0, 1'b0, 0);
        run_frame("thresh",   2'd2, 8'h00, 8'h80, 16'h0200, 16'h3000, 0, 1'b0, 0);
        run_frame("wrap",     2'd3, 8'h00, 8'h00, 16'hFFFE, 16'hFFFF, 0, 1'b0, 0);
        run_frame("abort3",   2'd1, 8'h20, 8'h00, 16'h0400, 16'h5000, 3, 1'b0, 0);
        run_frame("restart",  2'd0, 8'h05, 8'h00, 16'h0500, 16'h6000, 0, 1'b1, 0);
        run_frame("rst5",     2'd3, 8'h00, 8'h00, 16'h0600, 16'h7000, 0, 1'b0, 5);
        run_frame("postrst",  2'd1, 8'h40, 8'h00, 16'h0700, 16'h8000, 0, 1'b0, 0);
        for (int r = 0; r < 8; r++)
            run_frame($sformatf("rand%0d", r), 2'($urandom), 8'($urandom), 8'($urandom),
                      16'($urandom), 16'($urandom),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NP - 1)) : 0,
                      1'($urandom), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
